// File: rtl/demux_rr_dispatch_if.sv
// demux_rr_dispatch_if: input stream and per-channel output bundle
// master drives the input word and consumer readies; slave is the dispatcher
interface demux_rr_dispatch_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    localparam int NCH = 1 << SEL_W;

    logic                   mode;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [NCH*WIDTH-1:0]   out_data;
    logic [NCH-1:0]         out_valid;
    logic [NCH-1:0]         out_ready;
    logic [SEL_W-1:0]       rr_ptr;

    modport master (
        output mode,
        output in_data,
        output in_sel,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  rr_ptr
    );

    modport slave (
        input  mode,
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output rr_ptr
    );
endinterface

// File: rtl/demux_rr_dispatch.sv
// demux_rr_dispatch: 1:NCH dispatcher, round-robin or explicit select
// Optional DEMUX_SKIP_BUSY_EN: round-robin skips busy channels
module demux_rr_dispatch #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input logic               clk,
    input logic               rst_n,
    demux_rr_dispatch_if.slave bus
);
    localparam int NCH = 1 << SEL_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_st_e;

    ch_st_e           st_q   [NCH];
    ch_st_e           st_d   [NCH];
    logic [WIDTH-1:0] data_q [NCH];

    logic [SEL_W-1:0] rr_q;
    logic [SEL_W-1:0] rr_d;
    logic [SEL_W-1:0] tgt;
    logic [NCH-1:0]   free;
    logic [NCH-1:0]   drain;
    logic [NCH-1:0]   acc_vec;
    logic             rdy;
    logic             acc;

    // A channel is free when empty or draining in this cycle
    always_comb begin
        free  = '0;
        drain = '0;
        for (int k = 0; k < NCH; k++) begin
            drain[k] = (st_q[k] == FULL) && bus.out_ready[k];
            free[k]  = (st_q[k] == EMPTY) || bus.out_ready[k];
        end
    end

`ifdef DEMUX_SKIP_BUSY_EN
    logic [SEL_W-1:0] idx;
    logic             found;

    // Target select; round-robin falls through to the next free channel
    always_comb begin
        tgt   = bus.mode ? bus.in_sel : rr_q;
        rdy   = free[tgt];
        idx   = '0;
        found = 1'b0;
        if (!bus.mode && !free[rr_q]) begin
            for (int i = 1; i < NCH; i++) begin
                idx = rr_q + SEL_W'(i);
                if (!found && free[idx]) begin
                    tgt   = idx;
                    found = 1'b1;
                end
            end
            rdy = found;
        end
    end
`else
    // Target select; a busy round-robin target stalls the input
    always_comb begin
        tgt = bus.mode ? bus.in_sel : rr_q;
        rdy = free[tgt];
    end
`endif

    // One-hot accept strobe towards the target channel
    always_comb begin
        acc          = bus.in_valid && rdy;
        acc_vec      = '0;
        acc_vec[tgt] = acc;
    end

    // Channel next-state: fill on accept, empty on drain without refill
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            st_d[k] = st_q[k];
            unique case (st_q[k])
                EMPTY: begin
                    if (acc_vec[k]) st_d[k] = FULL;
                end
                FULL: begin
                    if (drain[k] && !acc_vec[k]) st_d[k] = EMPTY;
                end
                default: st_d[k] = EMPTY;
            endcase
        end
    end

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) st_q[k] <= EMPTY;
        end else begin
            for (int k = 0; k < NCH; k++) st_q[k] <= st_d[k];
        end
    end

    // Holding data; keeps its value after a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) data_q[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (acc_vec[k]) data_q[k] <= bus.in_data;
            end
        end
    end

    // Pointer moves past the channel just used, round-robin mode only
    always_comb begin
        rr_d = rr_q;
        if (acc && !bus.mode) rr_d = tgt + SEL_W'(1);
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end

    // Output decode from channel state and holding registers
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.out_valid[k]               = (st_q[k] == FULL);
            bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
        bus.in_ready = rdy;
        bus.rr_ptr   = rr_q;
    end
endmodule

// File: doc/demux_rr_dispatch.md
Name: demux_rr_dispatch

Overview:
- Sequential front end for the 1:4 demux path: accepts a single valid/ready input stream and routes each accepted word to one of NCH output channels.
- Channel select comes from an internal round-robin pointer or from an explicit per-word select input.
- Each output channel has a one-entry registered holding stage with its own valid/ready handshake, so a stalled consumer blocks only words destined for it.
- Sits directly upstream of the channel consumers, in place of a bare combinational demux.

Parameters:
- WIDTH, 8, data word width in bits.
- SEL_W, 2, select width; NCH = 2**SEL_W output channels (default 4).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately, release synchronous to clk.
- mode  input  1  0 = round-robin select, 1 = explicit select from in_sel.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  target channel; used only when mode=1.
- in_valid  input  1  input word valid.
- in_ready  output  1  dispatcher can accept the word presented this cycle.
- out_data  output  NCH*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
- out_valid  output  NCH  per-channel holding register valid.
- out_ready  input  NCH  per-channel consumer ready.
- rr_ptr  output  SEL_W  current round-robin pointer, for debug.

Behaviour:
- Reset, asynchronous on rst_n low, at any time including mid-transfer:
  - out_valid = 0, out_data = 0, rr_ptr = 0.
  - Any held words are discarded.
  - in_ready evaluates to 1 once reset is released.
- Target channel t:
  - mode=1: t = in_sel.
  - mode=0: t = rr_ptr.
- Channel k is free when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 (drains this cycle).
- in_ready = free(t), combinational from mode, in_sel, rr_ptr, out_valid, out_ready. No combinational path from in_valid to in_ready.
- Accept when in_valid && in_ready. On the next rising edge:
  - out_data[t] = in_data and out_valid[t] = 1.
  - Latency from accept to out_valid = 1 cycle.
- Drain: out_valid[k] && out_ready[k] with no new accept to k -> out_valid[k] = 0 next edge; out_data[k] holds its value.
- Simultaneous drain and accept on the same channel: the new word replaces the old one, out_valid stays 1. This gives full throughput of one word per cycle per channel.
- Round-robin pointer:
  - Advances by 1 modulo NCH only on an accept while mode=0; wraps from NCH-1 to 0.
  - Holds on stall, when mode=1, and on idle cycles.
  - A mode switch does not reset rr_ptr.
- Channels are independent: a stalled channel never blocks accepts to other channels in mode=1.
- Input side must hold in_data, in_sel and in_valid stable while in_valid=1 and in_ready=0. The block does not check this.
- Channel state machine, per channel:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on stall.

Optional Feature:
- Macro DEMUX_SKIP_BUSY_EN.
- Defined, mode=0 only: if rr_ptr's channel is not free, t becomes the first free channel scanning rr_ptr+1, rr_ptr+2, ... modulo NCH.
  - After an accept, rr_ptr = t+1 modulo NCH.
  - in_ready = 0 only when no channel is free.
- Not defined: strict round-robin as above; a busy target stalls the input.
- mode=1 behaviour is identical in both builds.

Test Plan:
- Reset mid-stream: out_valid=4'b0011, assert rst_n=0 without waiting for a clock edge -> out_valid=0, out_data=0, rr_ptr=0 immediately. After release, in_ready=1.
- Round-robin fill: mode=0, out_ready=0, send 0xA0,0xA1,0xA2,0xA3 -> channels 0..3 hold those values, out_valid=4'b1111, rr_ptr wraps to 0. The fifth word sees in_ready=0.
- Explicit select: mode=1, in_sel=2, data 0x5C -> out_valid=4'b0100 and channel 2 = 0x5C one cycle after accept, rr_ptr unchanged.
- Simultaneous drain and accept: channel 1 holds 0x11 with out_ready[1]=1, accept 0x22 to channel 1 in the same cycle -> next cycle out_valid[1]=1, data=0x22, in_ready stayed 1.
- Per-channel stall isolation: mode=1, out_ready[3]=0 with channel 3 full, send to channel 0 -> accepted. Send to channel 3 -> in_ready=0 until out_ready[3]=1.
- DEMUX_SKIP_BUSY_EN build: mode=0, rr_ptr=1, channel 1 full and stalled, channel 2 free, send 0x77 -> lands in channel 2, rr_ptr=3. Without the macro, in_ready=0.
